// File: rtl/ft_err_collector.sv
// Error-event collector: per-source edge counters, sticky/overflow flags, first-error record
// and a single acknowledged interrupt. Define FT_ERR_TS_EN to add the first-error timestamp.
module ft_err_collector #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned TS_WIDTH  = 16,
  localparam int unsigned SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [N_SRC-1:0]           err_i,
  input  logic                       clear_i,
  input  logic                       irq_ack_i,
  output logic                       irq_o,
  output logic [N_SRC-1:0]           sticky_o,
  output logic [N_SRC-1:0]           overflow_o,
  output logic [N_SRC*CNT_WIDTH-1:0] cnt_o,
  output logic                       first_valid_o,
`ifdef FT_ERR_TS_EN
  output logic [SRC_W-1:0]           first_src_o,
  output logic [TS_WIDTH-1:0]        first_ts_o
`else
  output logic [SRC_W-1:0]           first_src_o
`endif
);

  typedef enum logic [0:0] {StIdle, StPend} irq_state_e;

  irq_state_e           state_q, state_d;
  logic [N_SRC-1:0]     err_prev_q, err_prev_d;
  logic [N_SRC-1:0]     sticky_q, sticky_d;
  logic [N_SRC-1:0]     overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_SRC];
  logic [CNT_WIDTH-1:0] cnt_d [N_SRC];
  logic                 first_valid_q, first_valid_d;
  logic [SRC_W-1:0]     first_src_q, first_src_d;

  logic [N_SRC-1:0]     evt;
  logic [N_SRC-1:0]     acc;
  logic                 any_acc;
  logic [SRC_W-1:0]     low_idx;

  // Rising edges gated by enable; clear drops same-cycle events.
  always_comb begin
    evt        = err_i & ~err_prev_q;
    acc        = evt & {N_SRC{en_i & ~clear_i}};
    any_acc    = |acc;
    err_prev_d = err_i;
  end

  // Scan downwards so the lowest accepted index is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (acc[k]) begin
        low_idx = SRC_W'(k);
      end
    end
  end

  always_comb begin
    sticky_d      = sticky_q;
    overflow_d    = overflow_q;
    first_valid_d = first_valid_q;
    first_src_d   = first_src_q;
    for (int k = 0; k < N_SRC; k++) begin
      cnt_d[k] = cnt_q[k];
    end

    if (clear_i) begin
      sticky_d      = '0;
      overflow_d    = '0;
      first_valid_d = 1'b0;
      first_src_d   = '0;
      for (int k = 0; k < N_SRC; k++) begin
        cnt_d[k] = '0;
      end
    end else begin
      for (int k = 0; k < N_SRC; k++) begin
        if (acc[k]) begin
          sticky_d[k] = 1'b1;
          if (cnt_q[k] == {CNT_WIDTH{1'b1}}) begin
            overflow_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
      end
      if (!first_valid_q && any_acc) begin
        first_valid_d = 1'b1;
        first_src_d   = low_idx;
      end
    end
  end

  // An ack coinciding with a new event keeps the interrupt pending.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_acc) state_d = StPend;
      StPend:  if (irq_ack_i && !any_acc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      err_prev_q    <= '0;
      sticky_q      <= '0;
      overflow_q    <= '0;
      first_valid_q <= 1'b0;
      first_src_q   <= '0;
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      err_prev_q    <= err_prev_d;
      sticky_q      <= sticky_d;
      overflow_q    <= overflow_d;
      first_valid_q <= first_valid_d;
      first_src_q   <= first_src_d;
      for (int k = 0; k < N_SRC; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef FT_ERR_TS_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] first_ts_q, first_ts_d;

  always_comb begin
    ts_d       = ts_q + 1'b1;
    first_ts_d = first_ts_q;
    if (clear_i) begin
      first_ts_d = '0;
    end else if (!first_valid_q && any_acc) begin
      first_ts_d = ts_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      first_ts_q <= '0;
    end else begin
      ts_q       <= ts_d;
      first_ts_q <= first_ts_d;
    end
  end

  assign first_ts_o = first_ts_q;
`endif

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
    end
  end

  assign irq_o         = (state_q == StPend);
  assign sticky_o      = sticky_q;
  assign overflow_o    = overflow_q;
  assign first_valid_o = first_valid_q;
  assign first_src_o   = first_src_q;

endmodule

// File: tb/tb_ft_err_collector.sv
// Directed bench for ft_err_collector with a cycle-level reference model and a per-cycle compare.
module tb_ft_err_collector;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_i, en_i, clear_i, irq_ack_i;
  logic [N-1:0]  err_i;
  logic          irq_o, first_valid_o;
  logic [N-1:0]  sticky_o, overflow_o;
  logic [N*CW-1:0] cnt_o;
  logic [1:0]    first_src_o;
`ifdef FT_ERR_TS_EN
  logic [TW-1:0] first_ts_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ft_err_collector #(.N_SRC(N), .CNT_WIDTH(CW), .TS_WIDTH(TW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .irq_ack_i    (irq_ack_i),
    .irq_o        (irq_o),
    .sticky_o     (sticky_o),
    .overflow_o   (overflow_o),
    .cnt_o        (cnt_o),
    .first_valid_o(first_valid_o),
`ifdef FT_ERR_TS_EN
    .first_src_o  (first_src_o),
    .first_ts_o   (first_ts_o)
`else
    .first_src_o  (first_src_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer bookkeeping of the event rules.
  bit m_valid = 1'b0;
  int m_cnt [N];
  bit m_sticky [N];
  bit m_ovf [N];
  bit m_prev [N];
  bit m_fv, m_irq;
  int m_src, m_ts, m_fts;

  always @(posedge clk) begin
    bit acc [N];
    bit any;
    if (rst_i) begin
      m_valid = 1'b1;
      for (int k = 0; k < N; k++) begin
        m_cnt[k] = 0; m_sticky[k] = 0; m_ovf[k] = 0; m_prev[k] = 0;
      end
      m_fv = 0; m_irq = 0; m_src = 0; m_ts = 0; m_fts = 0;
    end else begin
      any = 0;
      for (int k = 0; k < N; k++) begin
        acc[k] = err_i[k] && !m_prev[k] && en_i && !clear_i;
        any = any | acc[k];
      end
      if (clear_i) begin
        for (int k = 0; k < N; k++) begin
          m_cnt[k] = 0; m_sticky[k] = 0; m_ovf[k] = 0;
        end
        m_fv = 0; m_src = 0; m_fts = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (acc[k]) begin
            m_sticky[k] = 1;
            if (m_cnt[k] == 255) m_ovf[k] = 1;
            else m_cnt[k] = m_cnt[k] + 1;
          end
        end
        if (!m_fv && any) begin
          m_fv = 1; m_fts = m_ts;
          for (int k = N - 1; k >= 0; k--) if (acc[k]) m_src = k;
        end
      end
      m_irq = any || (m_irq && !irq_ack_i);
      for (int k = 0; k < N; k++) m_prev[k] = err_i[k];
      m_ts = (m_ts + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    logic [N*CW-1:0] e_cnt;
    logic [N-1:0] e_st, e_ov;
    if (m_valid) begin
      for (int k = 0; k < N; k++) begin
        e_cnt[k*CW +: CW] = m_cnt[k][CW-1:0];
        e_st[k] = m_sticky[k];
        e_ov[k] = m_ovf[k];
      end
      check("model_irq", 64'(irq_o), 64'(m_irq));
      check("model_cnt", 64'(cnt_o), 64'(e_cnt));
      check("model_sticky", 64'(sticky_o), 64'(e_st));
      check("model_ovf", 64'(overflow_o), 64'(e_ov));
      check("model_fv", 64'(first_valid_o), 64'(m_fv));
      check("model_src", 64'(first_src_o), 64'(m_src));
`ifdef FT_ERR_TS_EN
      check("model_ts", 64'(first_ts_o), 64'(m_fts));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1; en_i = 1; clear_i = 0; irq_ack_i = 0; err_i = 4'b1111;

    // Reset with all flags high, then release: one event per source.
    tick(); tick();
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    check("rst_sticky", 64'(sticky_o), 64'd0);
    check("rst_fv", 64'(first_valid_o), 64'd0);
    rst_i = 0;
    tick();
    check("rel_cnt", 64'(cnt_o), 64'h01010101);
    check("rel_sticky", 64'(sticky_o), 64'hF);
    check("rel_src", 64'(first_src_o), 64'd0);
    check("rel_irq", 64'(irq_o), 64'd1);

    // Saturation on source 2.
    err_i = 4'b0000; irq_ack_i = 1; tick(); irq_ack_i = 0;
    for (int i = 0; i < 300; i++) begin
      err_i = 4'b0100; tick();
      err_i = 4'b0000; tick();
    end
    check("sat_cnt2", 64'(cnt_o[23:16]), 64'd255);
    check("sat_ovf", 64'(overflow_o), 64'b0100);
    check("sat_cnt0", 64'(cnt_o[7:0]), 64'd1);
    clear_i = 1; tick(); clear_i = 0;
    err_i = 4'b0100;
    repeat (50) tick();
    err_i = 4'b0000; tick();
    check("stuck_cnt2", 64'(cnt_o[23:16]), 64'd1);

    // Handshake.
    irq_ack_i = 1; tick(); irq_ack_i = 0; tick();
    check("hs_idle", 64'(irq_o), 64'd0);
    err_i = 4'b0010; tick(); err_i = 4'b0000;
    check("hs_pend", 64'(irq_o), 64'd1);
    repeat (5) tick();
    irq_ack_i = 1; tick(); irq_ack_i = 0;
    check("hs_ack", 64'(irq_o), 64'd0);
    irq_ack_i = 1; err_i = 4'b1000; tick(); irq_ack_i = 0; err_i = 4'b0000;
    check("hs_ack_evt", 64'(irq_o), 64'd1);
    irq_ack_i = 1; tick(); irq_ack_i = 0;

    // First-error priority.
    clear_i = 1; tick(); clear_i = 0;
    err_i = 4'b1010; tick(); err_i = 4'b0000;
    check("pri_src", 64'(first_src_o), 64'd1);
    check("pri_fv", 64'(first_valid_o), 64'd1);
    tick();
    err_i = 4'b0001; tick(); err_i = 4'b0000;
    check("pri_hold", 64'(first_src_o), 64'd1);
    check("pri_cnt0", 64'(cnt_o[7:0]), 64'd1);
    clear_i = 1; tick(); clear_i = 0;
    check("clr_fv", 64'(first_valid_o), 64'd0);
    check("clr_cnt", 64'(cnt_o), 64'd0);
    irq_ack_i = 1; tick(); irq_ack_i = 0;

    // Enable and clear collisions.
    en_i = 0; err_i = 4'b0100; tick(); en_i = 1; err_i = 4'b0000;
    check("en_cnt", 64'(cnt_o), 64'd0);
    check("en_irq", 64'(irq_o), 64'd0);
    err_i = 4'b0001; tick(); err_i = 4'b0000;
    check("pre_clr_irq", 64'(irq_o), 64'd1);
    clear_i = 1; err_i = 4'b0100; tick(); clear_i = 0; err_i = 4'b0000;
    check("clr_evt_cnt", 64'(cnt_o), 64'd0);
    check("clr_evt_irq", 64'(irq_o), 64'd1);

    // Mid-operation reset.
    err_i = 4'b0010; tick(); err_i = 4'b0000;
    rst_i = 1; tick(); rst_i = 0;
    check("mid_rst_irq", 64'(irq_o), 64'd0);
    check("mid_rst_cnt", 64'(cnt_o), 64'd0);

`ifdef FT_ERR_TS_EN
    // Reset edge leaves ts at 0; the 65536th edge after it samples ts = 16'hFFFF.
    en_i = 1; rst_i = 1; tick(); rst_i = 0;
    repeat (65535) tick();
    err_i = 4'b0001; tick(); err_i = 4'b0000;
    check("ts_ffff", 64'(first_ts_o), 64'hFFFF);
    check("ts_src", 64'(first_src_o), 64'd0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ft_err_collector.md
# ft_err_collector

Error-event collector for the fault-tolerance mechanisms: it consumes the error flags produced by the protection elements (time-redundant combinational checker, triplicated register, parity register, Hamming SEC-DED register). It turns them into per-source event counts, sticky status, a first-error record and a single interrupt with an acknowledge handshake. It sits between the protection elements and the SafeSU register interface or software, as the receiving end of the protection elements' error outputs.

## Interface
Parameters:
- N_SRC, 4, number of error sources (1..16)
- CNT_WIDTH, 8, width of each per-source saturating event counter
- TS_WIDTH, 16, width of the free-running timestamp counter
- SRC_W, derived, `$clog2(N_SRC)` with a minimum of 1; not overridable

Ports:
- clk_i, in, 1, clock; the block uses one clock only
- rst_i, in, 1, reset; synchronous, active-high
- en_i, in, 1, collection enable; while 0, events are ignored
- err_i, in, N_SRC, error flag per source (level)
- clear_i, in, 1, clears counters, sticky, overflow and the first-error record
- irq_ack_i, in, 1, interrupt acknowledge
- irq_o, out, 1, interrupt pending
- sticky_o, out, N_SRC, per-source "error seen" flag
- overflow_o, out, N_SRC, per-source counter saturated-and-hit flag
- cnt_o, out, N_SRC*CNT_WIDTH, packed counters; source k occupies bits [k*CNT_WIDTH +: CNT_WIDTH]
- first_valid_o, out, 1, first-error record valid
- first_src_o, out, SRC_W, index of the first erroring source
- first_ts_o, out, TS_WIDTH, timestamp of the first error (present only with FT_ERR_TS_EN)

## Operation
- **Event definition.** An event on source k is a rising edge of err_i[k]: err_i[k] is 1 this cycle and its registered previous value is 0.
  - A stuck-high flag counts once.
  - The previous-value register updates every cycle, regardless of en_i and clear_i.
- **Accepted events.** An event is accepted only when en_i=1 and clear_i=0.
- **Counters.** On an accepted event on source k:
  - cnt[k] increments.
  - If cnt[k] already equals all-ones, it holds and overflow_o[k] is set. overflow_o[k] is sticky.
  - sticky_o[k] is set.
- **First-error record.**
  - Loaded on the first accepted event while first_valid_o=0. first_valid_o is then set and the record holds until clear_i or reset.
  - Simultaneous events: the lowest-index source is recorded.
- **clear_i.** Zeroes all counters, sticky_o, overflow_o and first_valid_o/first_src_o/first_ts_o.
  - Any event in the same cycle is dropped; clear wins.
  - clear_i does not affect the interrupt FSM.
- **Interrupt FSM.** Two states, IDLE and PEND.
  - IDLE: irq_o=0. Any accepted event moves to PEND.
  - PEND: irq_o=1. If irq_ack_i=1 and there is no accepted event in the same cycle, move to IDLE. If irq_ack_i=1 and there is a new accepted event in the same cycle, stay in PEND so the event is not lost.
  - irq_ack_i in IDLE is ignored.
- **Timestamp.** A free-running TS_WIDTH counter.
  - Reset value 0; increments every cycle; wraps from all-ones to 0.
  - first_ts_o captures the counter value in the cycle the event is sampled.

## Timing
- All outputs are registered.
- An event sampled at clock edge t is visible on cnt_o, sticky_o, overflow_o, first_* and irq_o immediately after edge t, giving 1-cycle latency from err_i.
- irq_o deasserts in the cycle after the edge that samples irq_ack_i=1.
- clear_i takes effect after the edge that samples it.
- Reset (rst_i=1 at an edge), including mid-operation:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The timestamp and the previous-err register go to 0. A source already high when reset releases therefore counts as one event on the first enabled cycle.

## Configuration
- **FT_ERR_TS_EN defined:** the timestamp counter and the first_ts_o port exist and behave as specified above.
- **FT_ERR_TS_EN undefined:** the timestamp counter, the first_ts_o port and the capture logic are removed. All other behaviour is identical.

## Test plan
- **Reset:** hold rst_i=1 for 2 cycles with err_i=4'b1111 -> all outputs 0. Release with en_i=1 -> next edge: cnt of every source 1, sticky_o=4'hF, first_src_o=0, irq_o=1.
- **Edge detection and saturation:** CNT_WIDTH=8; pulse err_i[2] 300 times, separated by at least 1 low cycle -> cnt[2]=255, overflow_o[2]=1. Holding err_i[2] high for 50 cycles -> exactly 1 count.
- **Handshake:** event on src 1; wait 5 cycles; irq_ack_i=1 for 1 cycle -> irq_o=0 on the following cycle. Assert irq_ack_i together with a new event on src 3 -> irq_o stays 1.
- **First-error priority:** err_i rises on srcs 3 and 1 in the same cycle -> first_src_o=1. A later event on src 0 leaves first_src_o=1. clear_i -> first_valid_o=0, all cnt 0.
- **Enable and clear collisions:** an event with en_i=0 -> no count, no irq. An event in the same cycle as clear_i -> counters 0 and irq_o unchanged.
- **FT_ERR_TS_EN:** event on src 0 at timestamp 16'hFFFF -> first_ts_o=16'hFFFF. An event at the wrap cycle after clear -> first_ts_o=16'h0000.
